instr_mem_pipelined: RTL
========================

Name: instr_mem_pipelined

Overview:
- Parametrised instruction memory for the KGPRisc fetch stage; replaces the fixed 32x32 combinational-read instruction memory.
- Synchronous read with configurable pipeline latency, a fetch request/valid handshake with stall, an independent write port for program loading, and error flagging for out-of-range or misaligned fetches.
- Sits between the PC register and the decode stage.

Parameters:
DATA_W, 32, instruction word width in bits
ADDR_W, 32, address width of fetch and write addresses
DEPTH, 32, number of instruction words
LATENCY, 1, fetch latency in cycles; legal values are 1 and 2
BYTE_ADDR, 0, 0 = addresses are word indices; 1 = addresses are byte addresses (index = addr>>2, addr[1:0] must be 0)
NOP_WORD, 0, value returned on reset, on errors and for never-written words

Ports:
clka  input  1  clock, all state updates on the rising edge
rsta_n  input  1  reset, asynchronous, active-low
rd_req  input  1  fetch request
addra  input  ADDR_W  fetch address, sampled together with rd_req
stall  input  1  freezes the read pipeline and output registers
douta  output  DATA_W  fetched instruction
rd_valid  output  1  douta holds the result of one accepted fetch
rd_err  output  1  the accepted fetch was out of range or misaligned
wea  input  1  write enable for the load port
waddr  input  ADDR_W  write address (same addressing mode as addra)
dina  input  DATA_W  write data
wr_err  output  1  one-cycle pulse: the last write was rejected

Behaviour:
- Reset (rsta_n low, asynchronous): douta=NOP_WORD, rd_valid=0, rd_err=0, wr_err=0, and all pipeline valid bits are cleared.
  - The memory array is not cleared by reset.
  - Initial array content is NOP_WORD in every word.
  - Reset in the middle of a fetch discards that fetch; no rd_valid follows.
- Index and error: index = addr when BYTE_ADDR=0, and addr>>2 when BYTE_ADDR=1. An address is bad if index >= DEPTH, or if BYTE_ADDR=1 and addr[1:0]!=0.
- Write: on an edge with wea=1 and a good waddr, mem[index]<=dina.
  - A bad waddr leaves the array unchanged and sets wr_err=1 for exactly one cycle.
  - Writes are unaffected by stall.
- Fetch accept: a fetch is accepted on an edge where rd_req=1 and stall=0.
  - The array is read at that edge.
  - If a write targets the same index on the same edge, the fetch returns dina (write-first).
- LATENCY=1:
  - The edge after an accepted fetch's cycle presents douta=data, rd_valid=1, rd_err=error.
  - An edge with stall=0 and no request sets rd_valid=0 and keeps the previous douta.
- LATENCY=2:
  - One internal stage register holds (data, err, valid).
  - Outputs appear one edge after the stage is loaded, i.e. 2 edges after accept.
  - Throughput is one fetch per cycle.
- Bad fetch: douta=NOP_WORD, rd_valid=1, rd_err=1. Memory is never read out of bounds.
- Stall=1: every pipeline register and all outputs hold their values; rd_req is ignored, not queued.
  - Data already in the stage register is not overwritten, even if the memory changes meanwhile.
- rd_valid is high for one cycle per accepted fetch, except that it stays high while stall holds it.
- LATENCY values other than 1 and 2 are illegal; the design stops at elaboration.

Test Plan:
- Reset then idle → douta=0, rd_valid=0, rd_err=0. Fetch addra=5 with LATENCY=1 → next cycle douta=0, rd_valid=1.
- Write waddr=3, dina=32'h38230000, then fetch addra=3 → douta=32'h38230000 after 1 cycle (LATENCY=1) and after 2 cycles (LATENCY=2).
- Back-to-back fetches 1,2,3 with LATENCY=2 and contents 32'h38230000, 32'h30200003, 32'h34200003 → these appear on consecutive cycles 2..4, each with rd_valid=1.
- Fetch addra=40 with DEPTH=32 → rd_valid=1, rd_err=1, douta=0. Write waddr=40 → wr_err pulses for 1 cycle and the array is unchanged. With BYTE_ADDR=1, addra=6 → rd_err=1.
- Mid-stream stall: fetch 1, then stall=1 for 3 cycles with rd_req=1 and addra=2 → douta and rd_valid are frozen and fetch 2 is not accepted; after stall=0 the pipeline resumes correctly.
- Same-edge write and fetch to index 7 with dina=32'hDEADBEEF → returns 32'hDEADBEEF. Assert rsta_n low mid-fetch (LATENCY=2) → outputs clear immediately and no rd_valid pulse appears after release.

Source files
------------

// File: rtl/instr_mem_pipelined.sv
// rtl/instr_mem_pipelined.sv - parametrised pipelined instruction memory for the fetch stage
module instr_mem_pipelined #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 32,
  parameter int                 DEPTH     = 32,
  parameter int                 LATENCY   = 1,
  parameter int                 BYTE_ADDR = 0,
  parameter logic [DATA_W-1:0]  NOP_WORD  = '0
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] addra,
  input  logic              stall,
  output logic [DATA_W-1:0] douta,
  output logic              rd_valid,
  output logic              rd_err,
  input  logic              wea,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] dina,
  output logic              wr_err
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  // Power-up content is the NOP word; reset never touches the array.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

  logic [ADDR_W-1:0] rd_index;
  logic [ADDR_W-1:0] wr_index;
  logic              rd_bad;
  logic              wr_bad;
  logic [IDX_W-1:0]  rd_ix;
  logic [IDX_W-1:0]  wr_ix;
  logic              rd_acc;
  logic              wr_go;
  logic [DATA_W-1:0] rd_data;

  function automatic logic [ADDR_W-1:0] to_index(input logic [ADDR_W-1:0] a);
    if (BYTE_ADDR != 0) begin
      return a >> 2;
    end
    return a;
  endfunction

  function automatic logic is_bad(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] idx;
    idx = to_index(a);
    return (idx >= DEPTH_A) || ((BYTE_ADDR != 0) && (a[1:0] != 2'b00));
  endfunction

  // Address decode, accept/write qualification and write-first read mux.
  always_comb begin
    rd_index = to_index(addra);
    wr_index = to_index(waddr);
    rd_bad   = is_bad(addra);
    wr_bad   = is_bad(waddr);
    rd_ix    = rd_index[IDX_W-1:0];
    wr_ix    = wr_index[IDX_W-1:0];
    rd_acc   = rd_req && !stall;
    wr_go    = wea && !wr_bad;
    rd_data  = NOP_WORD;
    if (!rd_bad) begin
      if (wr_go && (wr_ix == rd_ix)) begin
        rd_data = dina;
      end else begin
        rd_data = mem[rd_ix];
      end
    end
  end

  // Load port: only in-range, aligned writes reach the array; stall has no effect.
  always_ff @(posedge clka) begin
    if (wr_go) begin
      mem[wr_ix] <= dina;
    end
  end

  // One-cycle rejection pulse for a bad write address.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wea && wr_bad;
    end
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      // Single register stage: outputs load directly from the array read.
      always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
          douta    <= NOP_WORD;
          rd_valid <= 1'b0;
          rd_err   <= 1'b0;
        end else if (!stall) begin
          rd_valid <= rd_acc;
          rd_err   <= rd_acc && rd_bad;
          if (rd_acc) begin
            douta <= rd_data;
          end
        end
      end
    end else if (LATENCY == 2) begin : g_lat2
      logic [DATA_W-1:0] s_data;
      logic              s_err;
      logic              s_valid;

      // Intermediate stage captures the read; frozen while stalled.
      always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
          s_data  <= NOP_WORD;
          s_err   <= 1'b0;
          s_valid <= 1'b0;
        end else if (!stall) begin
          s_valid <= rd_acc;
          if (rd_acc) begin
            s_data <= rd_data;
            s_err  <= rd_bad;
          end
        end
      end

      // Output stage forwards the intermediate stage; douta holds when empty.
      always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
          douta    <= NOP_WORD;
          rd_valid <= 1'b0;
          rd_err   <= 1'b0;
        end else if (!stall) begin
          rd_valid <= s_valid;
          rd_err   <= s_valid && s_err;
          if (s_valid) begin
            douta <= s_data;
          end
        end
      end
    end else begin : g_bad_latency
      $error("instr_mem_pipelined: LATENCY must be 1 or 2");
    end
  endgenerate

endmodule
